// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write path.
//   ADDR_W   - register address width
//   DATA_W   - register data width
//   REG_ZERO - hard-wired zero register; writes to it are dropped
//   req_id_e - writeback requester identity (ALU result vs memory load)
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rr_arb2: stateless two-input round-robin arbiter.
//   valid[1:0]  in   request valids (bit 0 = ALU, bit 1 = MEM)
//   last_grant  in   requester that won the most recent acceptance
//   grant[1:0]  out  one-hot grant (all zero when nothing is valid)
// The last_grant register lives in the caller, because only an accepted
// handshake (not a mere grant) may advance the rotation.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_e    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        // A lone valid always wins; on a tie the side that did not win last goes.
        grant[0] = valid[0] && (!valid[1] || (last_grant == REQ_MEM));
        grant[1] = valid[1] && (!valid[0] || (last_grant == REQ_ALU));
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single register-file write port between the
// ALU writeback (req0) and the memory-load writeback (req1).
//   clk, rst                   clock, asynchronous active-high reset
//   reqN_valid/addr/data       writeback requests
//   reqN_ready                 handshake: write accepted when ready && valid
//   hold                       pipeline freeze, blocks all acceptance
//   wr_en/wr_addr/wr_data      registered register-file write port
//   rd_addr0/rd_addr1          register-file read addresses being looked up
//   fwd0_hit/fwd1_hit          staged write matches the read address
//   fwd_data                   forwarding value (same as wr_data)
//   conflict_cnt               saturating count of unheld dual-valid cycles
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic              fwd0_hit,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    req_id_e           last_grant;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_mem;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              conflict;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Handshake gating: hold suppresses every ready, so nothing is accepted.
    assign req0_ready = grant[0] && !hold;
    assign req1_ready = grant[1] && !hold;
    assign accept     = req0_ready || req1_ready;
    assign sel_mem    = req1_ready;
    assign sel_addr   = sel_mem ? req1_addr : req0_addr;
    assign sel_data   = sel_mem ? req1_data : req0_data;
    assign conflict   = req0_valid && req1_valid && !hold;

    // Output stage. A register-0 write still completes its handshake and
    // loads addr/data, but the enable is withheld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= REQ_MEM;  // so req0 takes the first tie
        end else begin
            wr_en <= accept && (sel_addr != ADDR_W'(REG_ZERO));
            if (accept) begin
                wr_addr    <= sel_addr;
                wr_data    <= sel_data;
                last_grant <= sel_mem ? REQ_MEM : REQ_ALU;
            end
        end
    end

    // Saturating conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_cnt <= '0;
        else if (conflict && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
    end

    // Forwarding: wr_en already excludes register 0.
    assign fwd0_hit = wr_en && (wr_addr == rd_addr0);
    assign fwd1_hit = wr_en && (wr_addr == rd_addr1);
    assign fwd_data = wr_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk, rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready, hold;
    logic [AW-1:0] req0_addr, req1_addr, wr_addr, rd_addr0, rd_addr1;
    logic [DW-1:0] req0_data, req1_data, wr_data, fwd_data;
    logic          wr_en, fwd0_hit, fwd1_hit;
    logic [CW-1:0] conflict_cnt;

    int passed = 0;
    int total  = 0;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .hold(hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .fwd0_hit(fwd0_hit), .fwd1_hit(fwd1_hit), .fwd_data(fwd_data),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        #3;
        chk("rst_wr_en",   wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cnt",     conflict_cnt, 0);
        chk("rst_fwd0",    fwd0_hit, 0);
        @(negedge clk) rst = 1'b0;

        // req0 alone
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1111_1111; rd_addr0 = 5'd3;
        #1 chk("r0_ready", req0_ready, 1);
        chk("r0_r1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("r0_wr_en",   wr_en, 1);
        chk("r0_wr_addr", wr_addr, 3);
        chk("r0_wr_data", wr_data, 32'h1111_1111);
        chk("r0_fwd0",    fwd0_hit, 1);
        chk("r0_fwd1",    fwd1_hit, 0);
        chk("r0_fwd_data", fwd_data, 32'h1111_1111);
        tick();
        chk("idle_wr_en", wr_en, 0);

        // req1 writes register 0
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF; rd_addr0 = 5'd0;
        #1 chk("z_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("z_wr_en", wr_en, 0);
        chk("z_fwd0",  fwd0_hit, 0);
        chk("z_wr_data", wr_data, 32'hDEAD_BEEF);

        // dual contention, last grant = req1 so req0 leads
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA000_0001;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB000_0001;
        rd_addr0 = 5'd1; rd_addr1 = 5'd2;
        #1 chk("d1_ready0", req0_ready, 1);
        chk("d1_ready1", req1_ready, 0);
        tick();
        chk("d1_wr_addr", wr_addr, 1);
        chk("d1_wr_data", wr_data, 32'hA000_0001);
        chk("d1_fwd0", fwd0_hit, 1);
        chk("d1_fwd1", fwd1_hit, 0);
        req0_data = 32'hA000_0002;
        #1 chk("d2_ready1", req1_ready, 1);
        chk("d2_ready0", req0_ready, 0);
        tick();
        chk("d2_wr_data", wr_data, 32'hB000_0001);
        chk("d2_fwd1", fwd1_hit, 1);
        chk("d2_fwd0", fwd0_hit, 0);
        req1_data = 32'hB000_0002;
        #1 chk("d3_ready0", req0_ready, 1);
        tick();
        chk("d3_wr_data", wr_data, 32'hA000_0002);
        #1 chk("d4_ready1", req1_ready, 1);
        tick();
        chk("d4_wr_data", wr_data, 32'hB000_0002);
        chk("d4_cnt", conflict_cnt, 4);

        // hold for 3 cycles with both valid; staged req1 write still visible
        hold = 1'b1;
        #1 chk("h1_ready0", req0_ready, 0);
        chk("h1_ready1", req1_ready, 0);
        chk("h1_wr_en",  wr_en, 1);
        tick();
        chk("h2_wr_en", wr_en, 0);
        chk("h2_ready0", req0_ready, 0);
        tick();
        chk("h3_wr_en", wr_en, 0);
        tick();
        chk("h_wr_en", wr_en, 0);
        chk("h_cnt", conflict_cnt, 4);
        hold = 1'b0;
        #1 chk("rel_ready0", req0_ready, 1);
        chk("rel_ready1", req1_ready, 0);
        tick();
        chk("rel_cnt", conflict_cnt, 5);
        chk("rel_wr_addr", wr_addr, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // reset during a staged write
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_7777;
        tick();
        req0_valid = 1'b0;
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_wr_addr", wr_addr, 7);
        #2 rst = 1'b1;
        #1 chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_cnt", conflict_cnt, 0);
        @(negedge clk) rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        #1 chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        tick();
        chk("post_rst_cnt", conflict_cnt, 1);

        // saturation: 20 dual-valid cycles in total after reset
        for (int i = 0; i < 14; i++) tick();
        chk("sat_reach", conflict_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", conflict_cnt, 15);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
